// File: rtl/clk_div_pkg.sv
// Shared constants for the programmable clock divider.
package clk_div_pkg;

  // Default width of the division ratio input (largest ratio 2^3-1 = 7).
  localparam int RATIO_WD_DEF = 3;

  // Smallest ratio that actually divides; 0 and 1 fall back to bypass.
  localparam int MIN_DIV_RATIO = 2;

endpackage : clk_div_pkg

// File: rtl/clk_div_phase_cnt.sv
// Phase counter for the clock divider: generates the registered divided
// clock with a low phase of L = N - floor(N/2) cycles and a high phase of
// H = floor(N/2) cycles for ratio N.
module clk_div_phase_cnt
  import clk_div_pkg::*;
#(
  parameter int RATIO_WD = RATIO_WD_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                active,
  input  logic [RATIO_WD-1:0] ratio,
  output logic                div_clk
);

  logic [RATIO_WD-1:0] cnt;
  logic                div_clk_r;
  logic [RATIO_WD-1:0] hi_len;
  logic [RATIO_WD-1:0] lo_len;
  logic [RATIO_WD-1:0] hi_thr;
  logic [RATIO_WD-1:0] lo_thr;

  // Both lengths are >= 1 whenever active (N >= 2), so the -1 cannot wrap
  // in the cases that matter; the thresholds are ignored while inactive.
  assign hi_len = ratio >> 1;
  assign lo_len = ratio - hi_len;
  assign hi_thr = hi_len - RATIO_WD'(1);
  assign lo_thr = lo_len - RATIO_WD'(1);

  // Phase state machine: >= compares make a ratio change take effect on the
  // next edge without letting the counter run past the new threshold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      div_clk_r <= 1'b0;
    end else if (!active) begin
      cnt       <= '0;
      div_clk_r <= 1'b0;
    end else if (!div_clk_r && (cnt >= lo_thr)) begin
      cnt       <= '0;
      div_clk_r <= 1'b1;
    end else if (div_clk_r && (cnt >= hi_thr)) begin
      cnt       <= '0;
      div_clk_r <= 1'b0;
    end else begin
      cnt       <= cnt + RATIO_WD'(1);
    end
  end

  assign div_clk = div_clk_r;

endmodule : clk_div_phase_cnt

// File: rtl/clk_div.sv
// Programmable integer clock divider. Divides i_ref_clk by i_div_ratio when
// enabled and the ratio is at least 2; otherwise passes i_ref_clk straight
// through. A mode switch may produce one short pulse on the output.
module clk_div
  import clk_div_pkg::*;
#(
  parameter int RATIO_WD = RATIO_WD_DEF
) (
  input  logic                i_ref_clk,
  input  logic                i_rst_n,
  input  logic                i_clk_en,
  input  logic [RATIO_WD-1:0] i_div_ratio,
  output logic                o_div_clk
);

  logic div_active;
  logic div_clk_r;

  // Divide only when enabled and the ratio is a real division.
  assign div_active = i_clk_en && (i_div_ratio >= RATIO_WD'(MIN_DIV_RATIO));

  clk_div_phase_cnt #(
    .RATIO_WD (RATIO_WD)
  ) u_phase_cnt (
    .clk     (i_ref_clk),
    .rst_n   (i_rst_n),
    .active  (div_active),
    .ratio   (i_div_ratio),
    .div_clk (div_clk_r)
  );

  // Combinational output select: zero latency in bypass.
  assign o_div_clk = div_active ? div_clk_r : i_ref_clk;

endmodule : clk_div

// File: tb/tb_clk_div.sv
// Scoreboard bench for clk_div: stimulus pushes the expected output level
// for every half ref cycle; a monitor samples 2 ns after each ref edge and
// compares against the queue.
module tb_clk_div;

  localparam int RW = 3;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic [RW-1:0] ratio;
  logic          div_clk;

  typedef struct {
    logic  val;
    string tag;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  clk_div #(
    .RATIO_WD (RW)
  ) dut (
    .i_ref_clk   (clk),
    .i_rst_n     (rst_n),
    .i_clk_en    (en),
    .i_div_ratio (ratio),
    .o_div_clk   (div_clk)
  );

  // 10 ns reference clock, first rising edge at 5 ns.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic push(input logic v, input string tag);
    exp_t e;
    e.val = v;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic check_sample();
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (div_clk !== e.val) begin
        bad++;
        $display("FAIL %s: o_div_clk=%b required=%b at %0t", e.tag, div_clk, e.val, $time);
      end
    end
  endtask

  // Monitor: one sample in the high half and one in the low half of each cycle.
  always @(posedge clk) begin
    #2;
    check_sample();
  end

  always @(negedge clk) begin
    #2;
    check_sample();
  end

  // Level per ref cycle (after each rising edge), held for both samples.
  task automatic expect_div(input string tag, input string pat);
    for (int i = 0; i < pat.len(); i++) begin
      @(posedge clk);
      push(pat.getc(i) == "1", $sformatf("%s[%0d]h", tag, i));
      push(pat.getc(i) == "1", $sformatf("%s[%0d]l", tag, i));
    end
  endtask

  // Bypass: output mirrors the reference clock.
  task automatic expect_byp(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      push(1'b1, $sformatf("%s[%0d]h", tag, i));
      push(1'b0, $sformatf("%s[%0d]l", tag, i));
    end
  endtask

  // Change inputs 4 ns after a falling edge, after that half's sample.
  task automatic set_cfg(input logic r, input logic e, input logic [RW-1:0] n);
    @(negedge clk);
    #4;
    rst_n = r;
    en    = e;
    ratio = n;
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    ratio = 3'd2;

    // Reset with bypass selected: output follows the reference clock.
    expect_byp("rst_byp", 2);
    // Reset with divide selected: output held low.
    set_cfg(1'b0, 1'b1, 3'd2);
    expect_div("rst_div", "00");

    // Ratio 2 from reset release: first rise on the first edge.
    set_cfg(1'b1, 1'b1, 3'd2);
    expect_div("r2", "1010101010");

    // Ratio 1 and 0 bypass even when enabled.
    set_cfg(1'b1, 1'b1, 3'd1);
    expect_byp("r1_byp", 4);
    set_cfg(1'b1, 1'b1, 3'd0);
    expect_byp("r0_byp", 4);

    // Ratio 3: 2 low, 1 high.
    set_cfg(1'b1, 1'b0, 3'd3);
    expect_byp("en0_r3", 2);
    set_cfg(1'b1, 1'b1, 3'd3);
    expect_div("r3", "0100100100");

    // Ratio 4: 50% duty.
    set_cfg(1'b1, 1'b0, 3'd4);
    expect_byp("en0_r4", 2);
    set_cfg(1'b1, 1'b1, 3'd4);
    expect_div("r4", "0110011001");

    // Ratio 7 (largest): 4 low, 3 high.
    set_cfg(1'b1, 1'b0, 3'd7);
    expect_byp("en0_r7", 2);
    set_cfg(1'b1, 1'b1, 3'd7);
    expect_div("r7", "00011100001110");

    // Ratio 2 in bypass, then enable: clean low until next edge, then high.
    set_cfg(1'b1, 1'b0, 3'd2);
    expect_byp("en0_r2", 3);
    set_cfg(1'b1, 1'b1, 3'd2);
    expect_div("r2_en", "101010");

    // Ratio 5: 3 low, 2 high, then reset asserted mid high phase.
    set_cfg(1'b1, 1'b0, 3'd5);
    expect_byp("en0_r5", 2);
    set_cfg(1'b1, 1'b1, 3'd5);
    expect_div("r5", "0011000");
    @(posedge clk);
    push(1'b1, "r5_hi_before_rst");
    #3;
    rst_n = 1'b0;
    push(1'b0, "r5_async_rst");
    expect_div("r5_in_rst", "00");
    set_cfg(1'b1, 1'b1, 3'd5);
    expect_div("r5_after_rst", "0011000110");

    // Drain the scoreboard.
    repeat (2) @(posedge clk);
    #3;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: left=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: time=%0t required=finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_clk_div
